// File: rtl/serv_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) as a 32-bit Wishbone slave with prescaled tick
// and a level interrupt raised while mtime >= mtimecmp.
module serv_mtimer #(
    parameter RESET_STRATEGY = "MINI",
    parameter int DIV = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_mtip
);

    localparam bit FULL_RST = (RESET_STRATEGY != "NONE");
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   cmp_q, cmp_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   rdt_q, rdt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          mtip_q, mtip_d;
    logic          ack_q;
    logic          wr_en, rd_en, tick;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    always_comb begin
        wr_en    = i_wb_cyc & i_wb_we & ~ack_q;
        rd_en    = i_wb_cyc & ~i_wb_we & ~ack_q;
        tick     = (presc_q == PRESC_MAX);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        mtime_d  = tick ? mtime_q + 64'd1 : mtime_q;
        cmp_d    = cmp_q;
        shadow_d = shadow_q;
        rdt_d    = rdt_q;
        mtip_d   = (mtime_q >= cmp_q);

        // A bus write to either mtime half overrides the tick and leaves the other half untouched.
        if (wr_en) begin
            case (i_wb_adr)
                2'd0: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], i_wb_dat, i_wb_sel)};
                2'd1: mtime_d = {merge_bytes(mtime_q[63:32], i_wb_dat, i_wb_sel), mtime_q[31:0]};
                2'd2: cmp_d   = {cmp_q[63:32], merge_bytes(cmp_q[31:0], i_wb_dat, i_wb_sel)};
                default: cmp_d = {merge_bytes(cmp_q[63:32], i_wb_dat, i_wb_sel), cmp_q[31:0]};
            endcase
        end

        // Reading the low word latches the high word so a lo-then-hi read never tears.
        if (rd_en) begin
            case (i_wb_adr)
                2'd0: begin
                    rdt_d    = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                2'd1:    rdt_d = shadow_q;
                2'd2:    rdt_d = cmp_q[31:0];
                default: rdt_d = cmp_q[63:32];
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) ack_q <= 1'b0;
        else       ack_q <= i_wb_cyc & ~ack_q;
    end

    always_ff @(posedge i_clk) begin
        if (FULL_RST && i_rst) begin
            mtime_q  <= '0;
            presc_q  <= '0;
            cmp_q    <= '1;
            shadow_q <= '0;
            rdt_q    <= '0;
            mtip_q   <= 1'b0;
        end else begin
            mtime_q  <= mtime_d;
            presc_q  <= presc_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            rdt_q    <= rdt_d;
            mtip_q   <= mtip_d;
        end
    end

    assign o_wb_rdt = rdt_q;
    assign o_wb_ack = ack_q;
    assign o_mtip   = mtip_q;

endmodule

// File: tb/tb_serv_mtimer.sv
// Directed bench for serv_mtimer: two instances (DIV=1 and DIV=4) on a shared bus with
// separate cyc lines; read expectations go through a scoreboard queue.
module tb_serv_mtimer;

    logic        clk;
    logic        rst;
    logic        cyc1, cyc4, we;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdt1, rdt4;
    logic        ack1, ack4, mtip1, mtip4;

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    serv_mtimer #(.DIV(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc1), .i_wb_we(we), .i_wb_adr(adr),
        .i_wb_dat(dat), .i_wb_sel(sel), .o_wb_rdt(rdt1), .o_wb_ack(ack1), .o_mtip(mtip1)
    );

    serv_mtimer #(.DIV(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc4), .i_wb_we(we), .i_wb_adr(adr),
        .i_wb_dat(dat), .i_wb_sel(sel), .o_wb_rdt(rdt4), .o_wb_ack(ack4), .o_mtip(mtip4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One bus access; returns one cycle after the ack edge, at posedge+1.
    task automatic bus(input bit w4, input bit wr, input logic [1:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_v, input string tag);
        int n;
        logic got;
        logic [31:0] e;
        if (!wr) exp_q.push_back(exp_v);
        we  = wr;
        adr = a;
        dat = d;
        sel = s;
        if (w4) cyc4 = 1'b1;
        else    cyc1 = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(posedge clk);
            #1;
            n++;
            got = w4 ? ack4 : ack1;
        end
        chk({tag, "_ack"}, {31'b0, got}, 32'd1);
        if (!wr) begin
            e = exp_q.pop_front();
            chk(tag, w4 ? rdt4 : rdt1, e);
        end
        cyc1 = 1'b0;
        cyc4 = 1'b0;
        we   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        clk = 1'b0; rst = 1'b1; cyc1 = 1'b0; cyc4 = 1'b0; we = 1'b0;
        adr = 2'd0; dat = 32'd0; sel = 4'd0;
        checks = 0; failures = 0;

        // Reset state and free-running count at DIV=1
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ack1", {31'b0, ack1}, 32'd0);
        chk("rst_ack4", {31'b0, ack4}, 32'd0);
        chk("rst_rdt1", rdt1, 32'd0);
        chk("rst_rdt4", rdt4, 32'd0);
        chk("rst_mtip1", {31'b0, mtip1}, 32'd0);
        chk("rst_mtip4", {31'b0, mtip4}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("idle_mtip1", {31'b0, mtip1}, 32'd0);
        end
        bus(1'b0, 1'b0, 2'd0, 32'd0, 4'hF, 32'd10, "t1_lo");
        bus(1'b0, 1'b0, 2'd1, 32'd0, 4'hF, 32'd0, "t1_hi");
        bus(1'b1, 1'b0, 2'd2, 32'd0, 4'hF, 32'hFFFF_FFFF, "t1_cmplo4");
        bus(1'b1, 1'b0, 2'd3, 32'd0, 4'hF, 32'hFFFF_FFFF, "t1_cmphi4");

        // mtimecmp = 20: interrupt rises the cycle after mtime reaches 20
        do_reset();
        bus(1'b0, 1'b1, 2'd3, 32'd0, 4'hF, 32'd0, "t2_wcmphi");
        bus(1'b0, 1'b1, 2'd2, 32'd20, 4'hF, 32'd0, "t2_wcmplo");
        repeat (16) @(posedge clk);
        #1;
        chk("t2_mtip_pre", {31'b0, mtip1}, 32'd0);
        @(posedge clk);
        #1;
        chk("t2_mtip_rise", {31'b0, mtip1}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("t2_mtip_hold", {31'b0, mtip1}, 32'd1);
        end

        // DIV=4 carry across the word boundary, tear-free lo/hi read
        do_reset();
        bus(1'b1, 1'b1, 2'd1, 32'd0, 4'hF, 32'd0, "t3_whi");
        bus(1'b1, 1'b1, 2'd0, 32'hFFFF_FFFE, 4'hF, 32'd0, "t3_wlo");
        bus(1'b1, 1'b0, 2'd0, 32'd0, 4'hF, 32'hFFFF_FFFF, "t3_lo_a");
        repeat (2) @(posedge clk);
        #1;
        bus(1'b1, 1'b0, 2'd0, 32'd0, 4'hF, 32'h0000_0000, "t3_lo_b");
        bus(1'b1, 1'b0, 2'd1, 32'd0, 4'hF, 32'h0000_0001, "t3_hi_b");

        // Byte-lane write into mtime lo; DIV=1 always ticks in the write cycle
        do_reset();
        bus(1'b0, 1'b1, 2'd0, 32'hAABB_CCDD, 4'b0010, 32'd0, "t4_w1");
        bus(1'b0, 1'b0, 2'd0, 32'd0, 4'hF, 32'h0000_CC01, "t4_lo1");
        bus(1'b0, 1'b0, 2'd1, 32'd0, 4'hF, 32'h0000_0000, "t4_hi1");
        do_reset();
        bus(1'b1, 1'b1, 2'd0, 32'hAABB_CCDD, 4'b0010, 32'd0, "t4_w4a");
        bus(1'b1, 1'b0, 2'd0, 32'd0, 4'hF, 32'h0000_CC00, "t4_lo4a");
        repeat (3) @(posedge clk);
        #1;
        bus(1'b1, 1'b1, 2'd0, 32'hAABB_11DD, 4'b0010, 32'd0, "t4_w4b");
        bus(1'b1, 1'b0, 2'd0, 32'd0, 4'hF, 32'h0000_1101, "t4_lo4b");

        // 64-bit wrap with mtimecmp at all ones
        do_reset();
        bus(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF, 32'd0, "t5_whi");
        bus(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 4'hF, 32'd0, "t5_wlo");
        chk("t5_mtip_max", {31'b0, mtip1}, 32'd1);
        @(posedge clk);
        #1;
        chk("t5_mtip_drop", {31'b0, mtip1}, 32'd0);
        bus(1'b0, 1'b0, 2'd0, 32'd0, 4'hF, 32'd1, "t5_lo");
        bus(1'b0, 1'b0, 2'd1, 32'd0, 4'hF, 32'd0, "t5_hi");

        // Reset lands on the would-be ack edge of a mtimecmp write
        rst  = 1'b1;
        cyc1 = 1'b1;
        we   = 1'b1;
        adr  = 2'd2;
        dat  = 32'd5;
        sel  = 4'hF;
        @(posedge clk);
        #1;
        chk("t6_no_ack", {31'b0, ack1}, 32'd0);
        rst = 1'b0;
        we  = 1'b0;
        exp_q.push_back(32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        chk("t6_ack_after", {31'b0, ack1}, 32'd1);
        e = exp_q.pop_front();
        chk("t6_cmplo", rdt1, e);
        cyc1 = 1'b0;
        @(posedge clk);
        #1;
        bus(1'b0, 1'b0, 2'd3, 32'd0, 4'hF, 32'hFFFF_FFFF, "t6_cmphi");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t6_mtip", {31'b0, mtip1}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
